// File: rtl/instr_encoder.sv
// RV32 instruction encoder: turns symbolic instructions into 32-bit words with sequential word addresses,
// buffered in a 2-entry output FIFO. Define INSTR_ENC_RANGE_CHECK_EN to drop and flag out-of-range immediates.
module instr_encoder #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_SLLI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE= 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic [1:0]          count_q, count_d;
    logic                wr_ptr_q, rd_ptr_q;
    logic [31:0]         fifo_word_q [2];
    logic [ADDR_W-1:0]   fifo_addr_q [2];

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        imm12_bad, shamt_bad, bofs_bad;
    logic        accept, push, pop, restart;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    assign imm12_bad = in_imm[12] != in_imm[11];
    assign shamt_bad = |in_imm[12:5];
    assign bofs_bad  = in_imm[0];
`else
    assign imm12_bad = 1'b0;
    assign shamt_bad = 1'b0;
    assign bofs_bad  = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_op)
            OP_ADD:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SUB:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_AND:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
            OP_OR:   enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
            OP_MUL:  enc_word = {7'b0000001, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_ADDI: begin
                enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
                enc_legal = !imm12_bad;
            end
            OP_SLLI: begin
                enc_word  = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, OPC_I};
                enc_legal = !shamt_bad;
            end
            OP_LW: begin
                enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
                enc_legal = !imm12_bad;
            end
            OP_SW: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
                enc_legal = !imm12_bad;
            end
            OP_BEQ, OP_BNE: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b00, in_op == OP_BNE,
                             in_imm[4:1], in_imm[11], OPC_BR};
                enc_legal = !bofs_bad;
            end
            OP_HALT: enc_word = 32'h0000_007F;
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready  = (state_q == ST_RUN) && (count_q != 2'd2);
    assign out_valid = count_q != 2'd0;
    assign out_word  = fifo_word_q[rd_ptr_q];
    assign out_addr  = fifo_addr_q[rd_ptr_q];
    assign err       = err_q;
    assign done      = (state_q == ST_DONE) && (count_q == 2'd0);

    assign accept  = in_valid && in_ready;
    assign push    = accept && enc_legal;
    assign pop     = out_valid && out_ready;
    assign restart = start && ((state_q == ST_IDLE) || done);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (accept && in_op == OP_HALT) state_d = ST_DONE;
            ST_DONE: if (start && done) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        if (restart) begin
            addr_d = ADDR_W'(BASE_ADDR);
            err_d  = 1'b0;
        end else begin
            if (push)                 addr_d = addr_q + ADDR_W'(1);
            if (accept && !enc_legal) err_d  = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the two FIFO slots are reset too, so the head reads 0 out of reset instead of X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            err_q          <= 1'b0;
            count_q        <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_word_q[0] <= '0;
            fifo_word_q[1] <= '0;
            fifo_addr_q[0] <= '0;
            fifo_addr_q[1] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            count_q <= count_d;
            if (push) begin
                fifo_word_q[wr_ptr_q] <= enc_word;
                fifo_addr_q[wr_ptr_q] <= addr_q;
                wr_ptr_q              <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder, built with a 2-bit address so wrap-around is reachable.
module tb_instr_encoder;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n, start, in_valid, in_ready, out_valid, out_ready, err, done;
    logic [3:0]        in_op;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [12:0]       in_imm;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;

    int                vectors = 0;
    int                miscompares = 0;
    logic [ADDR_W-1:0] exp_addr;

    instr_encoder #(.BASE_ADDR(0), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .err(err), .done(done)
    );

    always #5 clk = !clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [12:0] imm);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Presents the current instruction and waits (bounded) for the handshake edge.
    task automatic send(input string name);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handshake: in_ready=%b after 20 cycles, required 1", name, in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic encode_one(input string name, input logic [3:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                              input logic [31:0] exp_word);
        set_instr(op, rd, rs1, rs2, imm);
        send(name);
        vectors++;
        if (out_valid !== 1'b1 || out_word !== exp_word) begin
            miscompares++;
            $display("FAIL %s word: got valid=%b word=%h, required valid=1 word=%h",
                     name, out_valid, out_word, exp_word);
        end
        vectors++;
        if (out_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL %s addr: got %0d, required %0d", name, out_addr, exp_addr);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({in_ready, out_valid, out_word, out_addr, err, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b word=%h addr=%0d err=%b done=%b, required all 0",
                     in_ready, out_valid, out_word, out_addr, err, done);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_not_ready: in_ready=%b, required 0", in_ready);
        end
        pulse_start();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_ready: in_ready=%b, required 1", in_ready);
        end
        exp_addr = '0;
    endtask

    task automatic test_rtype();
        set_instr(4'd0, 5'd3, 5'd1, 5'd2, 13'h1ABC);
        send("add");
        vectors++;
        if (out_valid !== 1'b1 || out_word !== 32'h002081B3 || out_addr !== 2'd0) begin
            miscompares++;
            $display("FAIL add_latency: got vld=%b word=%h addr=%0d, required 1 002081b3 0",
                     out_valid, out_word, out_addr);
        end
        set_instr(4'd4, 5'd5, 5'd6, 5'd7, 13'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_pop_ready: in_ready=%b at count 1, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_word !== 32'h027302B3 || out_addr !== 2'd1) begin
            miscompares++;
            $display("FAIL mul_push_pop: got vld=%b word=%h addr=%0d, required 1 027302b3 1",
                     out_valid, out_word, out_addr);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drained: out_valid=%b, required 0", out_valid);
        end
        exp_addr = 2'd2;
    endtask

    task automatic test_immediates();
        // Unused register fields carry junk that must not reach the word.
        encode_one("addi",  4'd5,  5'd1,  5'd0, 5'd31, 13'h1FFF, 32'hFFF00093);
        encode_one("sw",    4'd8,  5'd17, 5'd2, 5'd8,  13'd12,   32'h00812623);
        encode_one("bne",   4'd10, 5'd9,  5'd1, 5'd2,  13'h1FF8, 32'hFE209CE3);
        encode_one("sub",   4'd1,  5'd4,  5'd5, 5'd6,  13'd0,    32'h40628233);
        encode_one("and",   4'd2,  5'd7,  5'd8, 5'd9,  13'd0,    32'h009473B3);
        encode_one("or",    4'd3,  5'd10, 5'd11,5'd12, 13'd0,    32'h00C5E533);
        encode_one("slli",  4'd6,  5'd2,  5'd3, 5'd20, 13'd5,    32'h00519113);
        encode_one("lw",    4'd7,  5'd6,  5'd2, 5'd1,  13'h1FFC, 32'hFFC12303);
        encode_one("beq",   4'd9,  5'd0,  5'd3, 5'd4,  13'd16,   32'h00418863);
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_word [3];
        int accepted = 0;
        bp_word[0] = 32'h00100093;
        bp_word[1] = 32'h00200113;
        bp_word[2] = 32'h00300193;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            set_instr(4'd5, 5'(accepted + 1), 5'd0, 5'd0, 13'(accepted + 1));
            in_valid = 1'b1;
            if (in_ready) accepted++;
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_word !== bp_word[0] || out_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL bp_head_stable cycle %0d: got vld=%b word=%h addr=%0d, required 1 %h %0d",
                         cyc, out_valid, out_word, out_addr, bp_word[0], exp_addr);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (accepted != 2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept_count: accepted=%0d in_ready=%b, required 2 and 0", accepted, in_ready);
        end
        out_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full_pop_ready: in_ready=%b while popping at count 2, required 0", in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_word !== bp_word[1] || out_addr !== exp_addr + 2'd1) begin
            miscompares++;
            $display("FAIL bp_second: got vld=%b word=%h addr=%0d, required 1 %h %0d",
                     out_valid, out_word, out_addr, bp_word[1], exp_addr + 2'd1);
        end
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drained: out_valid=%b, required 0 (third word never accepted)", out_valid);
        end
        exp_addr = exp_addr + 2'd2;
    endtask

    task automatic test_illegal();
        set_instr(4'd12, 5'd1, 5'd2, 5'd3, 13'd4);
        send("illegal");
        vectors++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_drop: got vld=%b err=%b, required 0 and 1", out_valid, err);
        end
        pulse_start();
        vectors++;
        if (err !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_run: got err=%b in_ready=%b, required 1 and 1", err, in_ready);
        end
        encode_one("after_illegal", 4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
    endtask

    task automatic test_halt();
        set_instr(4'd15, 5'd7, 5'd7, 5'd7, 13'h0FFF);
        send("halt");
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h0000007F
            || out_addr !== exp_addr || done !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_emit: got rdy=%b vld=%b word=%h addr=%0d done=%b, required 0 1 0000007f %0d 0",
                     in_ready, out_valid, out_word, out_addr, done, exp_addr);
        end
        pulse_start();
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL start_undrained: got rdy=%b vld=%b, required 0 and 1", in_ready, out_valid);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_after_pop: got done=%b vld=%b, required 1 and 0", done, out_valid);
        end
        pulse_start();
        vectors++;
        if (in_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: got rdy=%b err=%b done=%b, required 1 0 0", in_ready, err, done);
        end
        exp_addr = '0;
        encode_one("restart_add", 4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3);
    endtask

    task automatic test_range();
        set_instr(4'd5, 5'd1, 5'd0, 5'd0, 13'd3000);
        send("addi_3000");
`ifdef INSTR_ENC_RANGE_CHECK_EN
        vectors++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL range_drop: got vld=%b err=%b, required 0 and 1", out_valid, err);
        end
`else
        vectors++;
        if (out_valid !== 1'b1 || out_word !== 32'hBB800093 || out_addr !== exp_addr || err !== 1'b0) begin
            miscompares++;
            $display("FAIL range_truncate: got vld=%b word=%h addr=%0d err=%b, required 1 bb800093 %0d 0",
                     out_valid, out_word, out_addr, err, exp_addr);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_addr = exp_addr + 1'b1;
`endif
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        set_instr(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        send("fill0");
        set_instr(4'd4, 5'd5, 5'd6, 5'd7, 13'd0);
        send("fill1");
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_before_reset: got rdy=%b vld=%b, required 0 and 1", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_word !== 32'd0 || out_addr !== '0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got vld=%b word=%h addr=%0d rdy=%b, required 0 0 0 0",
                     out_valid, out_word, out_addr, in_ready);
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_instr(4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
        test_reset();
        test_rtype();
        test_immediates();
        test_backpressure();
        test_illegal();
        test_halt();
        test_range();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32 instruction encoder: the inverse of the control decoder. It accepts symbolic instructions (op select plus register and immediate fields) over a valid/ready handshake. Each one is assembled into a 32-bit word that the decoder accepts, tagged with a sequential word address, and buffered in a 2-entry output FIFO. The downstream consumer is the instruction-memory loader.

## Interface
- `BASE_ADDR`, default 0: word address assigned to the first instruction after `start`.
- `ADDR_W`, default 10: width of `out_addr`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse; begins a program.
- `in_valid`  in  1  symbolic instruction present.
- `in_ready`  out  1  encoder accepts this cycle.
- `in_op`  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 ADDI, 6 SLLI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 15 HALT; 11–14 illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  13  signed immediate.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_word`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  word address of head.
- `err`  out  1  sticky illegal/range error.
- `done`  out  1  HALT encoded and FIFO drained.

## Operation
- **States:**
  - IDLE (reset): `in_ready`=0.
  - RUN: entered from IDLE on `start`, or from DONE on `start` when `done`=1. The address counter loads `BASE_ADDR` and `err` clears.
  - DONE: entered on acceptance of HALT.
  - `start` in RUN is ignored. `start` in DONE with `done`=0 is ignored.
- **`in_ready`** = (state==RUN) && (fifo_count<2). It has no combinational dependence on `out_ready`. Transfer occurs on `in_valid && in_ready`.
- **R-type (op 0–4):** opcode 0110011.
  - funct7/funct3: ADD 0000000/000, SUB 0100000/000, OR 0000000/110, AND 0000000/111, MUL 0000001/000.
- **ADDI:** opcode 0010011, funct3 000, imm[11:0] → word[31:20].
- **SLLI:** opcode 0010011, funct3 001, word[31:25]=0, word[24:20]=imm[4:0].
- **LW:** opcode 0000011, funct3 010, I-type immediate.
- **SW:** opcode 0100011, funct3 010, S-type split (imm[11:5] → [31:25], imm[4:0] → [11:7]).
- **BEQ/BNE:** opcode 1100011, funct3 000/001, B-type split of imm[12:1].
- **HALT:** word 32'h0000007F (opcode 1111111, all other fields 0).
- Unused register fields encode as 0.
- **Illegal op:** the instruction is accepted and dropped (no FIFO write, no address increment) and `err` is set.
- **Address counter:** increments by 1 per FIFO write, wraps modulo 2^ADDR_W. The head's address travels with its word.
- **`done`** = (state==DONE) && fifo_count==0.

## Timing
- **Reset values:** state IDLE, FIFO empty, `in_ready`=0, `out_valid`=0, `out_word`=0, `out_addr`=0, `err`=0, `done`=0.
- **Latency:** an accept at edge N gives `out_valid`=1 after edge N when the FIFO was empty. Words are emitted in acceptance order.
- **Throughput:** 1 word/cycle while the consumer keeps `out_ready`=1.
- **FIFO:**
  - A simultaneous push and pop with count 1 leaves count 1.
  - At count 2, `in_ready`=0 even if a pop occurs that cycle.
  - `out_word` and `out_addr` are held stable while `out_valid && !out_ready`.
- **HALT:** in_ready drops the cycle after HALT is accepted. `done` rises the cycle after the HALT word is popped.
- **Reset mid-operation:** asynchronous. The FIFO contents are discarded immediately.

## Configuration
- **`INSTR_ENC_RANGE_CHECK_EN` defined:**
  - ADDI/LW/SW with in_imm outside −2048..2047 is an error.
  - SLLI with in_imm outside 0..31 is an error.
  - BEQ/BNE with in_imm[0]=1 is an error.
  - On any of these, the instruction is dropped like an illegal op and `err` is set.
- **`INSTR_ENC_RANGE_CHECK_EN` undefined:** immediates are silently truncated to their field; `err` only reflects illegal ops.

## Test plan
- **Reset, then `start`:** ADD rd=3 rs1=1 rs2=2 → out_word 32'h002081B3, out_addr 0 one cycle later; next MUL rd=5 rs1=6 rs2=7 → 32'h027302B3 at addr 1.
- **Immediate forms:**
  - ADDI rd=1 rs1=0 imm=−1 → 32'hFFF00093.
  - SW rs1=2 rs2=8 imm=12 → 32'h00812623.
  - BNE rs1=1 rs2=2 imm=−8 → 32'hFE209CE3.
- **Backpressure:** out_ready=0 for 5 cycles with in_valid=1.
  - Exactly 2 words are accepted; `in_ready`=0 afterward; head is stable.
  - Release out_ready → order and addresses are preserved.
- **Illegal op 12:**
  - Accepted, with no output word and no address increment; `err`=1 until the next `start`.
- **HALT:**
  - HALT → 32'h0000007F is emitted, `in_ready` falls, and `done`=1 after the pop.
  - `start` then restarts at `BASE_ADDR` with `err` cleared.
- **Wrap and reset:**
  - With ADDR_W=2, five legal words give addresses 0, 1, 2, 3, 0.
  - Asserting rst_n=0 with a full FIFO drops `out_valid` with no clock edge.
  - With the macro defined, ADDI imm=3000 → dropped and `err`=1.
